// File: rtl/jtframe_z80wait_pkg.sv
// Shared definitions for the Z80 wait-state gate.
//   wait_state_e : controller states
//   lostw()      : width of the lost-enable counter for a given saturation value
package jtframe_z80wait_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROMWAIT = 2'd1,
    DEVWAIT = 2'd2,
    M1WAIT  = 2'd3
  } wait_state_e;

  function automatic int lostw(input int maxrec);
    return (maxrec < 1) ? 1 : $clog2(maxrec + 1);
  endfunction

endpackage

// File: rtl/jtframe_cenrec.sv
// Lost-enable bookkeeping and recovery pulse generation.
//   clk, rst   : system clock, synchronous active-high reset
//   cen_in     : raw CPU clock enable
//   gate       : effective gate (1 = CPU may run this cycle)
//   miss       : a cen_in pulse was withheld and must be paid back
//   rec_pulse  : extra enable issued to repay a lost one
//   lost       : current count of enables still owed
module jtframe_cenrec
  import jtframe_z80wait_pkg::*;
#(
  parameter int RECOVERY = 1,
  parameter int MAXREC   = 7,
  parameter int LOSTW    = lostw(MAXREC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen_in,
  input  logic             gate,
  input  logic             miss,
  output logic             rec_pulse,
  output logic [LOSTW-1:0] lost
);

  localparam logic [LOSTW-1:0] MAX_L = LOSTW'(MAXREC);

  logic [LOSTW-1:0] lost_q, lost_d;
  logic             cen_l_q, cen_l_d;

  always_comb begin
    rec_pulse = 1'b0;
    lost_d    = lost_q;
    if (RECOVERY != 0) begin
      // Only fire after a quiet cycle so two enables never land back to back.
      rec_pulse = ~rst & gate & ~cen_in & ~cen_l_q & (lost_q != '0);
      if (miss && (lost_q != MAX_L))
        lost_d = lost_q + 1'b1;
      else if (rec_pulse)
        lost_d = lost_q - 1'b1;
    end
    cen_l_d = (cen_in & gate) | rec_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q  <= '0;
      cen_l_q <= cen_in;
    end else begin
      lost_q  <= lost_d;
      cen_l_q <= cen_l_d;
    end
  end

  assign lost = lost_q;

endmodule

// File: rtl/jtframe_z80wait_multi.sv
// Clock-enable gate for Z80-class CPUs with several SDRAM ROM channels.
// Holds the CPU while a selected ROM channel has no data or a shared device
// is busy, optionally inserts M1 wait states, and repays withheld enables.
//   clk, rst          : system clock, synchronous active-high reset
//   cen_in / cen_out  : raw enable in, gated/recovered enable out
//   gate              : 1 = CPU running, 0 = stalled
//   mreq_n, iorq_n, m1_n, busak_n : CPU bus status
//   dev_busy          : shared device busy flags
//   rom_cs, rom_ok    : per-channel ROM select / data valid
//   lost              : enables still owed (debug)
//
// state   | meaning
// IDLE    | CPU running, decisions taken on cen_in cycles
// ROMWAIT | a selected ROM channel has not delivered data
// DEVWAIT | shared device busy during a memory/IO access
// M1WAIT  | fixed opcode-fetch wait states, not repaid
module jtframe_z80wait_multi
  import jtframe_z80wait_pkg::*;
#(
  parameter int CH       = 2,
  parameter int DEVW     = 1,
  parameter int M1_WAITS = 0,
  parameter int RECOVERY = 1,
  parameter int MAXREC   = 7,
  parameter int LOSTW    = lostw(MAXREC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen_in,
  output logic             cen_out,
  output logic             gate,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             m1_n,
  input  logic             busak_n,
  input  logic [DEVW-1:0]  dev_busy,
  input  logic [CH-1:0]    rom_cs,
  input  logic [CH-1:0]    rom_ok,
  output logic [LOSTW-1:0] lost
);

  localparam logic [2:0] M1_LOAD = 3'(M1_WAITS);

  wait_state_e state_q, state_d;
  logic        gate_q, gate_d;
  logic [2:0]  m1cnt_q, m1cnt_d;
  logic [CH-1:0] rom_cs_q;
  logic        m1_q;

  logic [CH-1:0] cs_rise;
  logic rom_pend, dev_pend, m1_new, gate_eff, miss, rec_pulse;

  always_comb begin
    // rom_ok may still be high from the previous access when cs rises
    cs_rise  = rom_cs & ~rom_cs_q;
    rom_pend = (|(rom_cs & ~(rom_ok & ~cs_rise))) & ~mreq_n & busak_n;
    dev_pend = (|dev_busy) & (~mreq_n | ~iorq_n) & busak_n;
    m1_new   = ~m1_n & m1_q & ~mreq_n;
    gate_eff = gate_q & ~rom_pend & ~dev_pend;
    miss     = cen_in & ~gate_eff & (state_q != M1WAIT);
    cen_out  = rst ? cen_in : ((cen_in & gate_eff) | rec_pulse);
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    m1cnt_d = m1cnt_q;
    case (state_q)
      IDLE: begin
        if (cen_in) begin
          if (rom_pend) begin
            state_d = ROMWAIT;
            gate_d  = 1'b0;
          end else if (dev_pend) begin
            state_d = DEVWAIT;
            gate_d  = 1'b0;
          end else if (m1_new && (M1_WAITS > 0)) begin
            state_d = M1WAIT;
            gate_d  = 1'b0;
            m1cnt_d = M1_LOAD;
          end
        end
      end
      ROMWAIT: begin
        if (!rom_pend) begin
          if (dev_pend) begin
            state_d = DEVWAIT;
          end else begin
            state_d = IDLE;
            gate_d  = 1'b1;
          end
        end
      end
      DEVWAIT: begin
        if (rom_pend) begin
          state_d = ROMWAIT;
        end else if (!dev_pend) begin
          state_d = IDLE;
          gate_d  = 1'b1;
        end
      end
      M1WAIT: begin
        if (cen_in) begin
          if (m1cnt_q <= 3'd1) begin
            m1cnt_d = 3'd0;
            state_d = IDLE;
            gate_d  = 1'b1;
          end else begin
            m1cnt_d = m1cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gate_d  = 1'b1;
        m1cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    rom_cs_q <= rom_cs;
    m1_q     <= m1_n;
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= 1'b1;
      m1cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      m1cnt_q <= m1cnt_d;
    end
  end

  assign gate = gate_q;

  jtframe_cenrec #(
    .RECOVERY (RECOVERY),
    .MAXREC   (MAXREC),
    .LOSTW    (LOSTW)
  ) u_cenrec (
    .clk       (clk),
    .rst       (rst),
    .cen_in    (cen_in),
    .gate      (gate_eff),
    .miss      (miss),
    .rec_pulse (rec_pulse),
    .lost      (lost)
  );

endmodule

// File: tb/tb_jtframe_z80wait_multi.sv
// Bench for jtframe_z80wait_multi: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural model that tracks
// "stalled", "M1 waits left" and "enables owed" as plain integers.
module tb_jtframe_z80wait_multi;

  localparam int CH     = 2;
  localparam int DEVW   = 1;
  localparam int M1W    = 2;
  localparam int MAXREC = 7;
  localparam int LW     = 3;

  logic clk = 1'b0;
  logic rst, cen_in, mreq_n, iorq_n, m1_n, busak_n;
  logic [DEVW-1:0] dev_busy;
  logic [CH-1:0]   rom_cs, rom_ok;
  logic            cen_out, gate;
  logic [LW-1:0]   lost;

  always #5 clk = ~clk;

  jtframe_z80wait_multi #(
    .CH(CH), .DEVW(DEVW), .M1_WAITS(M1W), .RECOVERY(1), .MAXREC(MAXREC), .LOSTW(LW)
  ) dut (
    .clk(clk), .rst(rst), .cen_in(cen_in), .cen_out(cen_out), .gate(gate),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .busak_n(busak_n),
    .dev_busy(dev_busy), .rom_cs(rom_cs), .rom_ok(rom_ok), .lost(lost)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_valid = 0;
  bit          m_stalled;
  int          m_m1_left, m_lost;
  bit          m_prev_out, m_prev_m1;
  bit [CH-1:0] m_prev_cs;

  int cyc      = 0;
  int cen_mode = 0;   // 0: every 4 clocks, 1: random
  int cnt_out, cnt_rec, gate_low, lost_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    cnt_out = 0; cnt_rec = 0; gate_low = 0; lost_max = 0;
  endtask

  // One clock: inputs set by the caller are already stable; check mid-cycle,
  // advance the model, then move past the next rising edge.
  task automatic step();
    bit rom_pend, dev_pend, pend, m1_new, exp_out, exp_gate;
    if (cen_mode == 0) cen_in = ((cyc % 4) == 0);
    else               cen_in = ($urandom_range(0, 2) == 0);
    cyc++;
    #3;
    rom_pend = 0;
    for (int i = 0; i < CH; i++)
      if (rom_cs[i] && !(rom_ok[i] && m_prev_cs[i])) rom_pend = 1;
    rom_pend = rom_pend && !mreq_n && busak_n;
    dev_pend = (dev_busy != '0) && (!mreq_n || !iorq_n) && busak_n;
    pend     = rom_pend || dev_pend;
    m1_new   = !m1_n && m_prev_m1 && !mreq_n;

    if (rst)                              exp_out = cen_in;
    else if (m_stalled || m_m1_left > 0)  exp_out = 0;
    else if (cen_in)                      exp_out = !pend;
    else                                  exp_out = !pend && (m_lost > 0) && !m_prev_out;
    exp_gate = !(m_stalled || m_m1_left > 0);

    if (m_valid) begin
      chk("cen_out", cen_out, exp_out);
      chk("gate", gate, exp_gate);
      chk("lost", lost, m_lost);
    end
    if (cen_out) cnt_out++;
    if (cen_out && !cen_in) cnt_rec++;
    if (!gate) gate_low++;
    if (int'(lost) > lost_max) lost_max = int'(lost);

    if (rst) begin
      m_stalled = 0; m_m1_left = 0; m_lost = 0; m_valid = 1;
    end else if (m_stalled) begin
      if (cen_in && m_lost < MAXREC) m_lost++;
      m_stalled = pend;
    end else if (m_m1_left > 0) begin
      if (cen_in) m_m1_left--;
    end else if (cen_in) begin
      if (pend) begin
        if (m_lost < MAXREC) m_lost++;
        m_stalled = 1;
      end else if (m1_new && M1W > 0) begin
        m_m1_left = M1W;
      end
    end else if (exp_out) begin
      m_lost--;
    end
    m_prev_out = exp_out;
    m_prev_cs  = rom_cs;
    m_prev_m1  = m1_n;

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1; cen_in = 0; mreq_n = 1; iorq_n = 1; m1_n = 1; busak_n = 1;
    dev_busy = '0; rom_cs = '0; rom_ok = '0;
    run(3);
    chk("reset_gate", gate, 1'b1);
    chk("reset_lost", lost, 0);
    rst = 0;
    run(4);

    // 1: ROM channel 1 misses for 10 clocks
    mreq_n = 0; rom_cs = 2'b10; rom_ok = 2'b00; cyc = 0; clr();
    run(10);
    rom_ok = 2'b10;
    run(54);
    chk("t1_gate_low", gate_low, 10);
    chk("t1_lost_max", lost_max, 3);
    chk("t1_cen_total", cnt_out, 16);
    chk("t1_rec", cnt_rec, 3);

    // 2: cs rises with stale ok on a cen_in cycle
    rom_cs = 2'b00; rom_ok = 2'b00; run(4);
    rom_cs = 2'b01; rom_ok = 2'b01; cyc = 0; clr();
    run(12);
    chk("t2_gate_low", gate_low, 1);
    chk("t2_rec", cnt_rec, 1);
    chk("t2_lost_end", lost, 0);

    // 3: long stall saturates the counter
    rom_cs = 2'b00; run(4);
    rom_cs = 2'b01; rom_ok = 2'b00; cyc = 0;
    run(160);
    chk("t3_lost_sat", lost, MAXREC);
    rom_ok = 2'b01; clr();
    run(40);
    chk("t3_rec", cnt_rec, 7);
    chk("t3_lost_end", lost, 0);

    // 4: M1 wait states
    cyc = 0; clr(); m1_n = 0;
    run(16);
    chk("t4_cen_out", cnt_out, 2);
    chk("t4_gate_low", gate_low, 8);
    chk("t4_lost_max", lost_max, 0);
    m1_n = 1; run(4);

    // 5: ROM and device stall together
    rom_cs = 2'b00; run(4);
    rom_cs = 2'b01; rom_ok = 2'b00; dev_busy = 1'b1; iorq_n = 0; cyc = 0; clr();
    run(8);
    rom_ok = 2'b01;
    run(8);
    chk("t5_gate_low_a", gate_low, 15);
    dev_busy = 1'b0;
    run(1);
    chk("t5_gate_low_b", gate_low, 16);
    run(30);
    chk("t5_lost_max", lost_max, 5);
    chk("t5_rec", cnt_rec, 5);
    iorq_n = 1;

    // 6: reset mid-stall, then busak_n masking
    rom_cs = 2'b00; run(4);
    rom_cs = 2'b01; rom_ok = 2'b00; cyc = 0;
    run(9);
    chk("t6_lost_pre", lost, 3);
    rom_ok = 2'b01; rst = 1;
    run(1);
    chk("t6_gate_rst", gate, 1'b1);
    chk("t6_lost_rst", lost, 0);
    rst = 0;
    rom_cs = 2'b10; rom_ok = 2'b00; busak_n = 0; cyc = 0; clr();
    run(8);
    chk("t6_busak_gate", gate_low, 0);
    chk("t6_busak_out", cnt_out, 2);
    busak_n = 1; cyc = 0;
    run(6);
    busak_n = 0;
    run(6);
    chk("t6_busak_exit", gate, 1'b1);
    busak_n = 1; rom_cs = 2'b00;
    run(20);

    // random traffic
    cen_mode = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) rom_cs   = CH'($urandom);
      if ($urandom_range(0, 3) == 0) rom_ok   = CH'($urandom);
      if ($urandom_range(0, 5) == 0) mreq_n   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) iorq_n   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) m1_n     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) dev_busy = DEVW'($urandom_range(0, 1));
      busak_n = ($urandom_range(0, 19) != 0);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
